// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scanner: active-low {g..a} segment
// patterns and the scan phase encoding.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_A    = 7'b0001000;
  localparam logic [6:0] SEG_B    = 7'b0000011;
  localparam logic [6:0] SEG_C    = 7'b1000110;
  localparam logic [6:0] SEG_D    = 7'b0100001;
  localparam logic [6:0] SEG_E    = 7'b0000110;
  localparam logic [6:0] SEG_F    = 7'b0001110;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } phase_t;

endpackage

// File: rtl/seg_decoder.sv
// Nibble to active-low segment pattern; BCD mode shows a dash for A..F.
module seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    if (!blank) begin
      case (nibble)
        4'h0: seg = SEG_0;
        4'h1: seg = SEG_1;
        4'h2: seg = SEG_2;
        4'h3: seg = SEG_3;
        4'h4: seg = SEG_4;
        4'h5: seg = SEG_5;
        4'h6: seg = SEG_6;
        4'h7: seg = SEG_7;
        4'h8: seg = SEG_8;
        4'h9: seg = SEG_9;
        4'hA: seg = hex_mode ? SEG_A : SEG_DASH;
        4'hB: seg = hex_mode ? SEG_B : SEG_DASH;
        4'hC: seg = hex_mode ? SEG_C : SEG_DASH;
        4'hD: seg = hex_mode ? SEG_D : SEG_DASH;
        4'hE: seg = hex_mode ? SEG_E : SEG_DASH;
        4'hF: seg = hex_mode ? SEG_F : SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed N-digit common-anode seven-segment driver with an
// inter-digit blanking window, leading-zero blanking and decimal points.
//
// state | meaning
// BLANK | first BLANK_CYCLES of a digit slot, all anodes off
// DRIVE | remainder of the slot, anode idx on, segments decoded
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digit,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    hex_mode,
  input  logic                    lz_blank,
  input  logic                    enable,
  output logic [6:0]              CA_CG,
  output logic                    DP,
  output logic [NUM_DIGITS-1:0]   AN
);

  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CW-1:0]         cnt, cnt_nxt;
  logic [IW-1:0]         idx, idx_nxt;
  phase_t                state, state_nxt;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  zero_run;
  logic [3:0]            nib;
  logic [6:0]            seg;

  always_comb begin
    cnt_nxt = cnt + 1'b1;
    idx_nxt = idx;
    if (cnt == CW'(DWELL_CYCLES - 1)) begin
      cnt_nxt = '0;
      idx_nxt = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BLANK: state_nxt = (cnt_nxt >= CW'(BLANK_CYCLES)) ? DRIVE : BLANK;
      DRIVE: state_nxt = ((cnt_nxt == '0) && (BLANK_CYCLES > 0)) ? BLANK : DRIVE;
      default: state_nxt = BLANK;
    endcase
  end

  // A digit is a leading zero when it and every more-significant nibble is zero.
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run && (digit[4*i +: 4] == 4'h0);
      lz_mask[i] = zero_run;
    end
  end

  // Decode the digit that will be shown after this edge, so outputs never lag idx.
  assign nib = digit[4*idx_nxt +: 4];

  seg_decoder u_dec (
    .nibble   (nib),
    .hex_mode (hex_mode),
    .blank    (lz_blank && lz_mask[idx_nxt]),
    .seg      (seg)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      cnt   <= '0;
      idx   <= '0;
      state <= BLANK;
      AN    <= '1;
      CA_CG <= SEG_OFF;
      DP    <= 1'b1;
    end else begin
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      state <= state_nxt;
      if (state_nxt == DRIVE) begin
        AN    <= ~(NUM_DIGITS'(1) << idx_nxt);
        CA_CG <= seg;
        DP    <= ~dp[idx_nxt];
      end else begin
        AN    <= '1;
        CA_CG <= SEG_OFF;
        DP    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with a 4-digit, 8-cycle dwell, 2-cycle blank setup.
module tb_seven_seg_scanner;

  localparam int ND = 4;
  localparam int DW = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digit;
  logic [3:0]  dp;
  logic        hex_mode;
  logic        lz_blank;
  logic        enable;
  logic [6:0]  CA_CG;
  logic        DP;
  logic [3:0]  AN;

  int cmp = 0;
  int err = 0;

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .NUM_DIGITS   (ND),
    .DWELL_CYCLES (DW),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .digit    (digit),
    .dp       (dp),
    .hex_mode (hex_mode),
    .lz_blank (lz_blank),
    .enable   (enable),
    .CA_CG    (CA_CG),
    .DP       (DP),
    .AN       (AN)
  );

  // Expected {AN, CA_CG, DP} after edge k of a scan; segs packed {d3,d2,d1,d0}.
  function automatic logic [11:0] exp_out(int k, logic [27:0] segs, logic [3:0] dpm);
    int c = k % DW;
    int i = (k / DW) % ND;
    if (c < BC) return {4'b1111, 7'h7F, 1'b1};
    return {~(4'b0001 << i), segs[7*i +: 7], ~dpm[i]};
  endfunction

  task automatic restart();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; hex_mode = 1'b0; lz_blank = 1'b0;
    digit = 16'h1234; dp = 4'b1111;
    repeat (3) @(negedge clk);
    cmp++; if (AN !== 4'b1111) begin err++; $display("FAIL reset AN got %b want 1111", AN); end
    cmp++; if (CA_CG !== 7'h7F) begin err++; $display("FAIL reset CA_CG got %b want 1111111", CA_CG); end
    cmp++; if (DP !== 1'b1) begin err++; $display("FAIL reset DP got %b want 1", DP); end
  endtask

  task automatic test_bcd_scan();
    logic [27:0] segs = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
    logic [11:0] e;
    digit = 16'h1234; dp = 4'b0000; hex_mode = 1'b0; lz_blank = 1'b0;
    restart();
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      e = exp_out(k, segs, dp);
      cmp++;
      if ({AN, CA_CG, DP} !== e) begin
        err++;
        $display("FAIL bcd_scan k=%0d AN/CA_CG/DP got %b/%b/%b want %b/%b/%b", k, AN, CA_CG, DP, e[11:8], e[7:1], e[0]);
      end
    end
  endtask

  task automatic test_dash_hex();
    logic [27:0] segs_bcd = {7'b1000000, 7'b1000000, 7'b0111111, 7'b0010010};
    logic [27:0] segs_hex = {7'b1000000, 7'b1000000, 7'b0001000, 7'b0010010};
    logic [11:0] e;
    digit = 16'h00A5; dp = 4'b0000; lz_blank = 1'b0;
    for (int m = 0; m < 2; m++) begin
      hex_mode = (m == 1);
      restart();
      for (int k = 1; k <= 34; k++) begin
        @(negedge clk);
        e = exp_out(k, (m == 1) ? segs_hex : segs_bcd, dp);
        cmp++;
        if ({AN, CA_CG, DP} !== e) begin
          err++;
          $display("FAIL dash_hex hex=%0d k=%0d AN/CA_CG/DP got %b/%b/%b want %b/%b/%b", m, k, AN, CA_CG, DP, e[11:8], e[7:1], e[0]);
        end
      end
    end
  endtask

  task automatic test_lz_blank();
    logic [27:0] segs = {7'b1111111, 7'b1111111, 7'b0011001, 7'b1000000};
    logic [11:0] e;
    digit = 16'h0040; dp = 4'b1000; hex_mode = 1'b0; lz_blank = 1'b1;
    restart();
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      e = exp_out(k, segs, dp);
      cmp++;
      if ({AN, CA_CG, DP} !== e) begin
        err++;
        $display("FAIL lz_blank k=%0d AN/CA_CG/DP got %b/%b/%b want %b/%b/%b", k, AN, CA_CG, DP, e[11:8], e[7:1], e[0]);
      end
    end
    lz_blank = 1'b0;
  endtask

  task automatic test_dp();
    logic [27:0] segs = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
    logic [11:0] e;
    digit = 16'h1234; dp = 4'b0100; hex_mode = 1'b0; lz_blank = 1'b0;
    restart();
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      e = exp_out(k, segs, dp);
      cmp++;
      if ({AN, CA_CG, DP} !== e) begin
        err++;
        $display("FAIL dp k=%0d AN/CA_CG/DP got %b/%b/%b want %b/%b/%b", k, AN, CA_CG, DP, e[11:8], e[7:1], e[0]);
      end
    end
  endtask

  task automatic test_enable_pulse();
    logic [27:0] segs = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
    logic [11:0] e;
    digit = 16'h1234; dp = 4'b0000; hex_mode = 1'b0; lz_blank = 1'b0;
    restart();
    repeat (20) @(negedge clk);
    e = exp_out(20, segs, dp);
    cmp++; if ({AN, CA_CG, DP} !== e) begin err++; $display("FAIL enable_pre AN/CA_CG/DP got %b/%b/%b want %b/%b/%b", AN, CA_CG, DP, e[11:8], e[7:1], e[0]); end
    enable = 1'b0;
    @(negedge clk);
    cmp++; if ({AN, CA_CG, DP} !== {4'b1111, 7'h7F, 1'b1}) begin err++; $display("FAIL enable_dark AN/CA_CG/DP got %b/%b/%b want 1111/1111111/1", AN, CA_CG, DP); end
    enable = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      e = exp_out(k, segs, dp);
      cmp++;
      if ({AN, CA_CG, DP} !== e) begin
        err++;
        $display("FAIL enable_resume k=%0d AN/CA_CG/DP got %b/%b/%b want %b/%b/%b", k, AN, CA_CG, DP, e[11:8], e[7:1], e[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [27:0] segs = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
    logic [11:0] e;
    digit = 16'h1234; dp = 4'b1000; hex_mode = 1'b0; lz_blank = 1'b0;
    restart();
    repeat (28) @(negedge clk);
    e = exp_out(28, segs, dp);
    cmp++; if ({AN, CA_CG, DP} !== e) begin err++; $display("FAIL reset_mid_pre AN/CA_CG/DP got %b/%b/%b want %b/%b/%b", AN, CA_CG, DP, e[11:8], e[7:1], e[0]); end
    rst_n = 1'b0;
    @(negedge clk);
    cmp++; if ({AN, CA_CG, DP} !== {4'b1111, 7'h7F, 1'b1}) begin err++; $display("FAIL reset_mid_dark AN/CA_CG/DP got %b/%b/%b want 1111/1111111/1", AN, CA_CG, DP); end
    rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      e = exp_out(k, segs, dp);
      cmp++;
      if ({AN, CA_CG, DP} !== e) begin
        err++;
        $display("FAIL reset_mid_resume k=%0d AN/CA_CG/DP got %b/%b/%b want %b/%b/%b", k, AN, CA_CG, DP, e[11:8], e[7:1], e[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bcd_scan();
    test_dash_hex();
    test_lz_blank();
    test_dp();
    test_enable_pulse();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Parametrised time-multiplexed driver for an N-digit common-anode seven-segment display. It is the successor to the fixed 4-digit BCD scanner. It adds:
- a configurable digit count and dwell time;
- an inter-digit blanking window that removes ghosting;
- hex/BCD decode modes, leading-zero blanking and per-digit decimal points;
- a display enable.

It sits between the game/score logic and the board's CA..CG/DP/AN pins.

## Interface
Parameters:
- NUM_DIGITS, 4, digits scanned (1..8)
- DWELL_CYCLES, 1000, clk cycles each digit slot lasts (≥ BLANK_CYCLES+1)
- BLANK_CYCLES, 16, cycles at the start of each slot with all anodes off (≥ 0)

Ports:
- clk  in  1  system clock
- rst_n  in  1  one clock; reset is synchronous and active-low
- digit  in  4*NUM_DIGITS  nibble i = digit[4i+3:4i], digit 0 rightmost
- dp  in  NUM_DIGITS  decimal point request per digit, active-high
- hex_mode  in  1  1 = decode 0–F, 0 = BCD
- lz_blank  in  1  1 = blank leading zeros
- enable  in  1  0 = display dark
- CA_CG  out  7  segments {g,f,e,d,c,b,a}, active-low
- DP  out  1  decimal point, active-low
- AN  out  NUM_DIGITS  anode enables, active-low, one-hot-low when driving

## Operation
Registers:
- slot counter cnt (0..DWELL_CYCLES-1)
- digit index idx (0..NUM_DIGITS-1)
- phase FSM with states BLANK and DRIVE

Reset (rst_n=0 at an edge): cnt=0, idx=0, state BLANK, AN all 1, CA_CG=7'h7F, DP=1.

Counter and FSM:
- cnt increments every cycle.
- At DWELL_CYCLES-1, cnt wraps to 0 and idx advances. idx wraps from NUM_DIGITS-1 to 0.
- State is BLANK while cnt < BLANK_CYCLES, otherwise DRIVE.
- With BLANK_CYCLES=0, BLANK is never entered.

Outputs are registered and updated on the same edge as cnt/idx, so they always match the current idx. There is no one-slot lag.
- BLANK: AN all 1, CA_CG=7'h7F, DP=1.
- DRIVE: AN[idx]=0 and all other AN bits 1. CA_CG = decode(nibble idx). DP = ~dp[idx].
- digit and dp are sampled every DRIVE cycle; mid-slot input changes appear on the next cycle.

Decode (active-low {g..a}):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- hex_mode=1: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- hex_mode=0 with a nibble ≥ 0xA: dash, 0111111.

Leading-zero blanking (lz_blank=1):
- Digit i (i ≥ 1) is blanked when nibbles NUM_DIGITS-1 down to i are all zero.
- Digit 0 is never blanked.
- A blanked digit drives CA_CG=7'h7F, but its anode is still asserted and DP still follows dp[i].

enable:
- enable=0 at an edge forces the reset state: cnt=0, idx=0, BLANK, dark outputs.
- The scan restarts from digit 0 on the first edge after enable returns to 1.

## Timing
- Full refresh period: NUM_DIGITS*DWELL_CYCLES cycles.
- After rst_n rises, edge k (k=1,2,…) sets cnt=k mod DWELL.
- AN[0] goes low after edge BLANK_CYCLES and stays low for DWELL_CYCLES-BLANK_CYCLES cycles.
- AN[j] goes low after edge j*DWELL_CYCLES+BLANK_CYCLES.
- There is never a cycle where two AN bits are 0.
- There is never a cycle where AN changes between digits without at least BLANK_CYCLES dark cycles in between (when BLANK_CYCLES>0).
- Latency from a digit change to the segments is 1 cycle if the digit is in DRIVE, otherwise until its next DRIVE.
- rst_n low mid-slot: outputs go dark on that edge; there are no partial slots afterwards.

## Structure
- Package seven_seg_pkg holds:
  - the segment constants (SEG_0..SEG_F, SEG_DASH, SEG_OFF), active-low, {g..a} order;
  - the phase enum (BLANK, DRIVE).
- Sub-module seg_decoder, combinational:
  - inputs: nibble, hex_mode, blank
  - output: 7-bit pattern
- The scanner instantiates seg_decoder once, on the idx-selected nibble.

## Test plan
1. NUM_DIGITS=4, DWELL=8, BLANK=2, digit=16'h1234, hex_mode=0, lz_blank=0 → per 32-cycle period:
   - AN sequence 1110, 1101, 1011, 0111, each low for 6 cycles after 2 dark cycles;
   - CA_CG 0011001, 0110000, 0100100, 1111001 respectively.
2. Same setup, digit=16'h00A5, hex_mode=0 → digit1 shows 0111111 (dash). With hex_mode=1 → digit1 shows 0001000 (A).
3. digit=16'h0040, lz_blank=1 → digits 3 and 2 show 7'h7F with their AN still asserted. Digit 1 shows 4 (0011001). Digit 0 shows 0 (1000000).
4. dp=4'b0100 → DP=0 only during digit 2's DRIVE window, 1 otherwise, including all BLANK cycles.
5. Pulse enable=0 for 1 cycle mid-digit-2 → next cycle AN=1111 and CA_CG=7'h7F. Scan resumes at digit 0 with cnt=0.
6. Assert rst_n=0 during DRIVE of digit 3 → on that edge AN=1111, CA_CG=7'h7F, DP=1. After release, the timing of test 1 is reproduced from digit 0.
